// File: rtl/vga_score_ctrl_if.sv
// vga_score_ctrl_if: score/scan bus between the scan generator and vga_score_ctrl
interface vga_score_ctrl_if;
   logic        inc;
   logic        clear;
   logic        frame_start;
   logic [9:0]  row;
   logic [9:0]  col;
   logic [11:0] score_bcd;
   logic        saturated;
   logic [3:0]  seg_digit;
   logic [9:0]  seg_row;
   logic [9:0]  seg_col;
   logic        seg_valid;
   logic [11:0] hi_bcd;
   modport master (output inc, clear, frame_start, row, col,
                   input score_bcd, saturated, seg_digit, seg_row, seg_col, seg_valid, hi_bcd);
   modport slave  (input inc, clear, frame_start, row, col,
                   output score_bcd, saturated, seg_digit, seg_row, seg_col, seg_valid, hi_bcd);
endinterface

// File: rtl/vga_score_ctrl.sv
// vga_score_ctrl: 3-digit BCD score with tear-free snapshot and digit-cell scheduler; VGA_HISCORE_EN adds a high-score register
module vga_score_ctrl #(
   parameter int XBASE  = 560,
   parameter int YBASE  = 16,
   parameter int PITCH  = 24,
   parameter int HEIGHT = 32
) (
   input logic clk,
   input logic reset_n,
   vga_score_ctrl_if.slave bus
);
   localparam logic [9:0] X0 = 10'(XBASE);
   localparam logic [9:0] X1 = 10'(XBASE + PITCH);
   localparam logic [9:0] X2 = 10'(XBASE + 2 * PITCH);
   localparam logic [9:0] X3 = 10'(XBASE + 3 * PITCH);
   localparam logic [9:0] Y0 = 10'(YBASE);
   localparam logic [9:0] Y1 = 10'(YBASE + HEIGHT);
   logic [11:0] score, disp, score_inc;
   logic        sat, in_row, c0, c1, c2, v;
   logic [3:0]  d, seg_digit;
   logic [9:0]  org, seg_row, seg_col;
   logic        seg_valid;
   // BCD +1 with per-digit wrap and carry
   always_comb begin
      sat = score == 12'h999;
      score_inc[3:0]  = score[3:0] == 4'd9 ? 4'd0 : score[3:0] + 4'd1;
      score_inc[7:4]  = score[3:0] != 4'd9 ? score[7:4] : score[7:4] == 4'd9 ? 4'd0 : score[7:4] + 4'd1;
      score_inc[11:8] = score[7:0] == 8'h99 ? score[11:8] + 4'd1 : score[11:8];
   end
   // score counter (clear wins over inc) and frame snapshot of the pre-update score
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         score <= '0;
         disp  <= '0;
      end else begin
         if (bus.frame_start) disp <= score;
         if (bus.clear) score <= '0;
         else if (bus.inc && !sat) score <= score_inc;
      end
   end
   // cell decode against the snapshot, with leading-zero blanking
   always_comb begin
      in_row = bus.row >= Y0 && bus.row < Y1;
      c0 = in_row && bus.col >= X0 && bus.col < X1;
      c1 = in_row && bus.col >= X1 && bus.col < X2;
      c2 = in_row && bus.col >= X2 && bus.col < X3;
      org = c0 ? X0 : c1 ? X1 : X2;
      d = c0 ? disp[11:8] : c1 ? disp[7:4] : disp[3:0];
      v = c0 ? disp[11:8] != 4'd0 : c1 ? disp[11:4] != 8'd0 : c2;
   end
   // one-stage renderer pipeline; outside the field everything reads zero
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seg_digit <= '0;
         seg_row   <= '0;
         seg_col   <= '0;
         seg_valid <= 1'b0;
      end else begin
         seg_digit <= (c0 | c1 | c2) ? d : 4'd0;
         seg_row   <= (c0 | c1 | c2) ? bus.row - Y0 : 10'd0;
         seg_col   <= (c0 | c1 | c2) ? bus.col - org : 10'd0;
         seg_valid <= v;
      end
   end
   assign bus.score_bcd = score;
   assign bus.saturated = sat;
   assign bus.seg_digit = seg_digit;
   assign bus.seg_row   = seg_row;
   assign bus.seg_col   = seg_col;
   assign bus.seg_valid = seg_valid;
`ifdef VGA_HISCORE_EN
   logic [11:0] hi;
   // high score captures the finishing score on clear; digit-wise BCD order equals binary order
   always_ff @(posedge clk) begin
      if (!reset_n) hi <= '0;
      else if (bus.clear && score > hi) hi <= score;
   end
   assign bus.hi_bcd = hi;
`else
   assign bus.hi_bcd = 12'h000;
`endif
endmodule

// File: tb/tb_vga_score_ctrl.sv
// tb_vga_score_ctrl: directed and random checks of vga_score_ctrl against an integer score model
module tb_vga_score_ctrl;
   localparam int XB = 560, YB = 16, P = 24, H = 32;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   vga_score_ctrl_if bus();
   vga_score_ctrl #(.XBASE(XB), .YBASE(YB), .PITCH(P), .HEIGHT(H)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   int n_assert = 0, n_fail = 0;
   int m_score = 0, m_disp = 0, m_hi = 0;
   int e_dig = 0, e_row = 0, e_col = 0;
   bit e_val = 0;
   function automatic logic [11:0] bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction
   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic pix(input int r, input int c);
      int k;
      e_dig = 0; e_row = 0; e_col = 0; e_val = 0;
      if (r >= YB && r < YB + H && c >= XB && c < XB + 3 * P) begin
         k = (c - XB) / P;
         e_dig = k == 0 ? m_disp / 100 : k == 1 ? (m_disp / 10) % 10 : m_disp % 10;
         e_val = k == 2 || (k == 1 && m_disp >= 10) || (k == 0 && m_disp >= 100);
         e_col = c - XB - k * P;
         e_row = r - YB;
      end
   endtask
   task automatic tick(input bit rn, input bit i, input bit c, input bit f, input int r, input int cc);
      reset_n = rn; bus.inc = i; bus.clear = c; bus.frame_start = f;
      bus.row = 10'(r); bus.col = 10'(cc);
      @(posedge clk); #1;
      if (!rn) begin
         m_score = 0; m_disp = 0; m_hi = 0;
         e_dig = 0; e_row = 0; e_col = 0; e_val = 0;
      end else begin
         pix(r, cc);
         if (f) m_disp = m_score;
         if (c) begin
`ifdef VGA_HISCORE_EN
            if (m_score > m_hi) m_hi = m_score;
`endif
            m_score = 0;
         end else if (i && m_score < 999) m_score++;
      end
      check("score", bus.score_bcd, bcd(m_score));
      check("saturated", 12'(bus.saturated), 12'(m_score == 999));
      check("seg_digit", 12'(bus.seg_digit), 12'(e_dig));
      check("seg_row", 12'(bus.seg_row), 12'(e_row));
      check("seg_col", 12'(bus.seg_col), 12'(e_col));
      check("seg_valid", 12'(bus.seg_valid), 12'(e_val));
      check("hi_bcd", bus.hi_bcd, bcd(m_hi));
   endtask
   task automatic incs(input int n);
      for (int j = 0; j < n; j++) tick(1, 1, 0, 0, 0, 0);
   endtask
   initial begin
      bus.inc = 0; bus.clear = 0; bus.frame_start = 0; bus.row = '0; bus.col = '0;
      tick(0, 1, 0, 1, YB + 1, XB + 1);
      tick(0, 0, 0, 0, YB + 1, XB + 2 * P + 1);
      check("reset_score", bus.score_bcd, 12'h000);
      incs(123);
      tick(1, 0, 0, 1, 0, 0);
      tick(1, 0, 0, 0, YB + 3, XB + 5);
      check("r37_digit", 12'(bus.seg_digit), 12'd1);
      check("r37_col", 12'(bus.seg_col), 12'd5);
      check("r37_row", 12'(bus.seg_row), 12'd3);
      check("r37_valid", 12'(bus.seg_valid), 12'd1);
      tick(1, 0, 1, 0, 0, 0); incs(10);
      check("r38_010", bus.score_bcd, 12'h010);
      tick(1, 0, 1, 0, 0, 0); incs(100);
      check("r38_100", bus.score_bcd, 12'h100);
      tick(1, 0, 1, 0, 0, 0); incs(1001);
      check("r38_999", bus.score_bcd, 12'h999);
      check("r38_sat", 12'(bus.saturated), 12'd1);
      tick(1, 0, 1, 0, 0, 0); incs(7);
      tick(1, 0, 0, 1, 0, 0);
      tick(1, 0, 0, 0, YB + 1, XB + 2);
      check("r39_hund_valid", 12'(bus.seg_valid), 12'd0);
      tick(1, 0, 0, 0, YB + 1, XB + P + 2);
      check("r39_tens_valid", 12'(bus.seg_valid), 12'd0);
      tick(1, 0, 0, 0, YB + 1, XB + 2 * P + 2);
      check("r39_ones_valid", 12'(bus.seg_valid), 12'd1);
      check("r39_ones_digit", 12'(bus.seg_digit), 12'd7);
      tick(0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0); incs(42);
      tick(1, 1, 1, 0, 0, 0);
      check("r40_score", bus.score_bcd, 12'h000);
`ifdef VGA_HISCORE_EN
      check("r40_hi", bus.hi_bcd, 12'h042);
`else
      check("r40_hi", bus.hi_bcd, 12'h000);
`endif
      tick(1, 0, 1, 0, 0, 0); incs(5);
      tick(1, 1, 0, 1, 0, 0);
      tick(1, 0, 0, 0, YB, XB + 2 * P);
      check("r41_first", 12'(bus.seg_digit), 12'd5);
      tick(1, 0, 0, 1, 0, 0);
      tick(1, 0, 0, 0, YB + H - 1, XB + 3 * P - 1);
      check("r41_second", 12'(bus.seg_digit), 12'd6);
      tick(1, 0, 0, 0, YB + 2, XB + 3 * P);
      check("r42_col_edge", 12'(bus.seg_valid), 12'd0);
      tick(1, 0, 0, 0, YB + H, XB + 2 * P + 1);
      check("r42_row_edge", 12'(bus.seg_valid), 12'd0);
      tick(1, 0, 0, 0, YB - 1, XB + 2 * P + 1);
      tick(1, 0, 0, 0, YB + 2, XB - 1);
      tick(1, 0, 0, 0, YB + 2, XB + 2 * P + 1);
      check("r42_pre_reset", 12'(bus.seg_valid), 12'd1);
      tick(0, 0, 0, 0, YB + 2, XB + 2 * P + 1);
      check("r42_reset_blank", 12'(bus.seg_valid), 12'd0);
      tick(1, 1, 0, 0, YB + 2, XB + 2 * P + 1);
      check("r42_zero_digit", 12'(bus.seg_digit), 12'd0);
      for (int j = 0; j < 4000; j++)
         tick($urandom_range(299) != 0, $urandom_range(1) == 1, $urandom_range(63) == 0,
              $urandom_range(15) == 0, YB - 4 + int'($urandom_range(H + 8)),
              XB - 6 + int'($urandom_range(3 * P + 12)));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
